// File: rtl/rgb_stream_out.sv
// Reads packed RGB pairs (3 x 16-bit words per 2 pixels) from SRAM through a small prefetch FIFO
// and streams unpacked 8-bit R/G/B at a fixed cadence. Optional checksum: PIXEL_CHECKSUM_EN.
module rgb_stream_out #(
  parameter int unsigned    AW             = 18,
  parameter int unsigned    DW             = 16,
  parameter int unsigned    IMAGE_WIDTH    = 320,
  parameter int unsigned    IMAGE_HEIGHT   = 240,
  parameter logic [AW-1:0]  ADDR_RGB_PIXEL = 18'h23E00,
  parameter int unsigned    PIX_DIV        = 2,
  parameter int unsigned    FIFO_DEPTH     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata,
  output logic          vgastart,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          pix_valid,
  output logic          underrun
`ifdef PIXEL_CHECKSUM_EN
  ,
  output logic [15:0]   checksum
`endif
);

  localparam int unsigned NPIX        = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned TOTAL_WORDS = NPIX * 3 / 2;
  localparam int unsigned WCW         = $clog2(TOTAL_WORDS + 1);
  localparam int unsigned PCW         = $clog2(NPIX);
  localparam int unsigned PW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = PW + 1;
  localparam int unsigned DCW         = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [WCW-1:0] TotalW  = WCW'(TOTAL_WORDS);
  localparam logic [PCW-1:0] LastPix = PCW'(NPIX - 1);
  localparam logic [CW-1:0]  DepthC  = CW'(FIFO_DEPTH);
  localparam logic [DCW-1:0] DivLast = DCW'(PIX_DIV - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPrefetch = 2'd1;
  localparam logic [1:0] StStream   = 2'd2;
  localparam logic [1:0] StDone     = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [WCW-1:0] words_q, words_d;
  logic           infl_q, infl_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PCW-1:0] pix_q, pix_d;
  logic [DCW-1:0] div_q, div_d;
  logic [7:0]     hold_q, hold_d;
  logic [7:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic           pix_valid_q, pix_valid_d;
  logic           vgastart_q, vgastart_d;
  logic           done_q, done_d;
  logic           underrun_q, underrun_d;
  logic [DW-1:0]  mem_q [FIFO_DEPTH];
  logic [DW-1:0]  word_a, word_b;
  logic           issue;
  logic           push;
  logic [1:0]     pop_n;
`ifdef PIXEL_CHECKSUM_EN
  logic [15:0]    chk_q, chk_d;
`endif

  // Each read returns exactly one cycle later, so at most one read is ever in flight.
  assign push = infl_q;

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    div_d       = div_q;
    hold_d      = hold_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    pix_valid_d = 1'b0;
    vgastart_d  = 1'b0;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    pop_n       = 2'd0;
    word_a      = mem_q[rd_ptr_q];
    word_b      = mem_q[rd_ptr_q + PW'(1)];
`ifdef PIXEL_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    issue   = ((state_q == StPrefetch) || (state_q == StStream)) && (words_q < TotalW) &&
              ((cnt_q + CW'(infl_q)) < DepthC);
    infl_d  = issue;
    words_d = words_q + WCW'(issue);

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StPrefetch;
          underrun_d = 1'b0;
          words_d    = '0;
          pix_d      = '0;
`ifdef PIXEL_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      StPrefetch: begin
        if ((cnt_q == DepthC) || ((words_q == TotalW) && !infl_q)) begin
          state_d    = StStream;
          vgastart_d = 1'b1;
          div_d      = '0;
        end
      end
      StStream: begin
        if (div_q == '0) begin
          div_d = DivLast;
          if (!pix_q[0]) begin
            // Even pixel consumes w0 and w1; R of the odd pixel is parked in hold.
            if (cnt_q >= CW'(2)) begin
              pop_n       = 2'd2;
              r_d         = word_a[15:8];
              g_d         = word_a[7:0];
              b_d         = word_b[15:8];
              hold_d      = word_b[7:0];
              pix_valid_d = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            if (cnt_q != '0) begin
              pop_n       = 2'd1;
              r_d         = hold_q;
              g_d         = word_a[15:8];
              b_d         = word_a[7:0];
              pix_valid_d = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
          end
          if (pix_valid_d) begin
            pix_d = pix_q + PCW'(1);
            if (pix_q == LastPix) begin
              state_d = StDone;
            end
          end
        end else begin
          div_d = div_q - DCW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        words_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cnt_d    = cnt_q + CW'(push) - CW'(pop_n);
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(push);

`ifdef PIXEL_CHECKSUM_EN
    if (pix_valid_d) begin
      chk_d = {chk_q[14:0], chk_q[15]} ^ {r_d, g_d} ^ {8'h00, b_d};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      words_q     <= '0;
      infl_q      <= 1'b0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      pix_q       <= '0;
      div_q       <= '0;
      hold_q      <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      pix_valid_q <= 1'b0;
      vgastart_q  <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef PIXEL_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      words_q     <= words_d;
      infl_q      <= infl_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pix_q       <= pix_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      pix_valid_q <= pix_valid_d;
      vgastart_q  <= vgastart_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
`ifdef PIXEL_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sram_rdata;
    end
  end

  assign sram_raddr = ADDR_RGB_PIXEL + AW'(words_q);
  assign done       = done_q;
  assign vgastart   = vgastart_q;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign pix_valid  = pix_valid_q;
  assign underrun   = underrun_q;
`ifdef PIXEL_CHECKSUM_EN
  assign checksum   = chk_q;
`endif

endmodule

// File: tb/tb_rgb_stream_out.sv
// Bench for rgb_stream_out: three instances (2x1 div2, 16x8 div2 near address wrap, 4x2 div1)
// driven by small SRAM models; expected pixels come from a hand-filled table or a ramp model.
module tb_rgb_stream_out;

  localparam logic [17:0] A_BASE = 18'h23E00;
  localparam logic [17:0] B_BASE = 18'h3FF80;
  localparam logic [17:0] C_BASE = 18'h23E00;

  typedef struct packed {
    logic [15:0] w0, w1, w2;
    logic [7:0]  r0, g0, b0, r1, g1, b1;
  } pair_t;

  pair_t tbl [5];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] st;
  int         sel;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic        a_done, a_vs, a_pv, a_ur, b_done, b_vs, b_pv, b_ur, c_done, c_vs, c_pv, c_ur;
  logic [17:0] a_raddr, b_raddr, c_raddr;
  logic [15:0] a_rdata, b_rdata, c_rdata;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
`ifdef PIXEL_CHECKSUM_EN
  logic [15:0] a_chk, b_chk, c_chk;
`endif

  logic        m_pv, m_vs, m_done, m_ur;
  logic [7:0]  m_r, m_g, m_b;
  logic [17:0] m_raddr;

  always #10 clk = ~clk;

  rgb_stream_out #(.IMAGE_WIDTH(2), .IMAGE_HEIGHT(1), .ADDR_RGB_PIXEL(A_BASE), .PIX_DIV(2))
  u_a (.clk(clk), .reset(rst_n), .start(st[0]), .done(a_done), .sram_raddr(a_raddr),
       .sram_rdata(a_rdata), .vgastart(a_vs), .r(a_r), .g(a_g), .b(a_b), .pix_valid(a_pv),
       .underrun(a_ur)
`ifdef PIXEL_CHECKSUM_EN
       , .checksum(a_chk)
`endif
      );

  rgb_stream_out #(.IMAGE_WIDTH(16), .IMAGE_HEIGHT(8), .ADDR_RGB_PIXEL(B_BASE), .PIX_DIV(2))
  u_b (.clk(clk), .reset(rst_n), .start(st[1]), .done(b_done), .sram_raddr(b_raddr),
       .sram_rdata(b_rdata), .vgastart(b_vs), .r(b_r), .g(b_g), .b(b_b), .pix_valid(b_pv),
       .underrun(b_ur)
`ifdef PIXEL_CHECKSUM_EN
       , .checksum(b_chk)
`endif
      );

  rgb_stream_out #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .ADDR_RGB_PIXEL(C_BASE), .PIX_DIV(1))
  u_c (.clk(clk), .reset(rst_n), .start(st[2]), .done(c_done), .sram_raddr(c_raddr),
       .sram_rdata(c_rdata), .vgastart(c_vs), .r(c_r), .g(c_g), .b(c_b), .pix_valid(c_pv),
       .underrun(c_ur)
`ifdef PIXEL_CHECKSUM_EN
       , .checksum(c_chk)
`endif
      );

  function automatic logic [15:0] tbl_word(input int rec, input int j);
    if (j == 0) return tbl[rec].w0;
    if (j == 1) return tbl[rec].w1;
    return tbl[rec].w2;
  endfunction

  // Word k of each DUT's image (k = offset from its base address).
  function automatic logic [15:0] word_at(input int s, input logic [17:0] k);
    if (s == 1) return {~k[7:0], k[7:0]};
    if (s == 0) return (k < 18'd3) ? tbl_word(0, int'(k)) : 16'hDEAD;
    return (k < 18'd12) ? tbl_word(1 + int'(k) / 3, int'(k) % 3) : 16'hDEAD;
  endfunction

  function automatic logic [23:0] exp_pix(input int s, input int idx);
    int          q;
    logic [15:0] w0, w1, w2;
    q = idx / 2;
    if (s == 1) begin
      w0 = word_at(1, 18'(3 * q));
      w1 = word_at(1, 18'(3 * q + 1));
      w2 = word_at(1, 18'(3 * q + 2));
      return (idx % 2 == 0) ? {w0, w1[15:8]} : {w1[7:0], w2};
    end
    if (s == 2) q = q + 1;
    return (idx % 2 == 0) ? {tbl[q].r0, tbl[q].g0, tbl[q].b0} : {tbl[q].r1, tbl[q].g1, tbl[q].b1};
  endfunction

  always @(posedge clk) begin
    a_rdata <= word_at(0, 18'(a_raddr - A_BASE));
    b_rdata <= word_at(1, 18'(b_raddr - B_BASE));
    c_rdata <= word_at(2, 18'(c_raddr - C_BASE));
  end

  always_comb begin
    m_pv = a_pv; m_vs = a_vs; m_done = a_done; m_ur = a_ur;
    m_r = a_r; m_g = a_g; m_b = a_b; m_raddr = a_raddr;
    if (sel == 1) begin
      m_pv = b_pv; m_vs = b_vs; m_done = b_done; m_ur = b_ur;
      m_r = b_r; m_g = b_g; m_b = b_b; m_raddr = b_raddr;
    end else if (sel == 2) begin
      m_pv = c_pv; m_vs = c_vs; m_done = c_done; m_ur = c_ur;
      m_r = c_r; m_g = c_g; m_b = c_b; m_raddr = c_raddr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int s, input int npix, input int total, input bit poke,
                           input bit exp_under);
    int          pix, vcnt, dcnt, vcyc, steps, bad, tail;
    bit          poked;
    logic [17:0] prev;
    pix = 0; vcnt = 0; dcnt = 0; vcyc = 0; steps = 0; bad = 0; tail = -1; poked = 0;
    sel = s;
    @(negedge clk);
    prev  = m_raddr;
    st[s] = 1'b1;
    @(negedge clk);
    st = '0;
    for (int cyc = 0; cyc < 20 * npix + 100; cyc++) begin
      @(negedge clk);
      st = '0;
      if (poke && (cyc == 1 || (pix == 5 && !poked))) begin
        st[s] = 1'b1;
        if (cyc != 1) poked = 1;
      end
      if (m_done) begin
        dcnt++;
        if (tail < 0) tail = 4;
      end
      if (dcnt == 0 && m_raddr != prev) begin
        if (m_raddr == 18'(prev + 18'd1)) steps++;
        else bad++;
      end
      prev = m_raddr;
      if (m_vs) begin
        vcnt++;
        vcyc = cyc;
      end
      if (m_pv) begin
        check($sformatf("pix%0d_s%0d", pix, s), {8'h0, m_r, m_g, m_b}, {8'h0, exp_pix(s, pix)});
        if (s == 0) check($sformatf("pv_cycle%0d", pix), cyc - vcyc, 1 + 2 * pix);
`ifdef PIXEL_CHECKSUM_EN
        if (s == 0) check($sformatf("checksum%0d", pix), {16'h0, a_chk},
                          (pix == 0) ? 32'h1111 : 32'h6611);
`endif
        pix++;
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    check($sformatf("pix_count_s%0d", s), pix, npix);
    check($sformatf("vgastart_count_s%0d", s), vcnt, 1);
    check($sformatf("done_count_s%0d", s), dcnt, 1);
    check($sformatf("read_count_s%0d", s), steps, total);
    check($sformatf("addr_jumps_s%0d", s), bad, 0);
    check($sformatf("underrun_s%0d", s), {31'h0, m_ur}, {31'h0, exp_under});
  endtask

  initial begin
    tbl[0] = '{16'h1122, 16'h3344, 16'h5566, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    tbl[1] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    tbl[2] = '{16'h0102, 16'h0304, 16'h0506, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    tbl[3] = '{16'hFF00, 16'h8001, 16'h7F10, 8'hFF, 8'h00, 8'h80, 8'h01, 8'h7F, 8'h10};
    tbl[4] = '{16'h1357, 16'h9BDF, 16'h2468, 8'h13, 8'h57, 8'h9B, 8'hDF, 8'h24, 8'h68};
    st    = '0;
    sel   = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs_a", {a_done, a_vs, a_pv, a_ur, a_r, a_g, a_b}, 32'h0);
    check("rst_raddr_a", {14'h0, a_raddr}, {14'h0, A_BASE});
    check("rst_raddr_b", {14'h0, b_raddr}, {14'h0, B_BASE});
    rst_n = 1'b1;

    run_frame(0, 2, 3, 1'b0, 1'b0);
    run_frame(2, 8, 12, 1'b0, 1'b1);
    run_frame(1, 128, 192, 1'b1, 1'b0);

    // Abort mid-stream, then replay the whole frame.
    sel = 1;
    @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    st = '0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 400 && seen < 10; i++) begin
        @(negedge clk);
        if (b_pv) seen++;
      end
      check("midstream_reached", seen, 10);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_outs", {b_done, b_vs, b_pv, b_ur, b_r, b_g, b_b}, 32'h0);
    check("abort_raddr", {14'h0, b_raddr}, {14'h0, B_BASE});
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", {30'h0, b_done, b_pv}, 32'h0);
    end
    rst_n = 1'b1;
    run_frame(1, 128, 192, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
